// File: rtl/auto_player.sv
// auto_player
// Automatic song sequencer for auto-play mode. Walks a song ROM note by note,
// times every note with an internal tick prescaler and follows each note with
// a silent articulation gap. Supports pause/resume, next/previous song,
// repeat modes, tempo scaling and a done flag.
//
// Ports
//   clk, rst                  clock and asynchronous active-high reset
//   en                        auto mode enable; low forces IDLE
//   song_sel                  start song, sampled while in IDLE
//   pause_tgl, next_p, prev_p single-cycle control pulses
//   repeat_mode               00/11 next song, 01 repeat song, 10 stop at end
//   tempo                     right-shift applied to note durations
//   rom_song, rom_idx         ROM address (song, note index)
//   rom_track                 index of the last note of rom_song
//   rom_octave/note/length    combinational ROM data for the current address
//   octave, note              registered current note
//   gate                      tone enable
//   led                       one-hot note bar (bit note-1) while gate is high
//   playing                   high in LOAD/PLAY/GAP
//   done                      high in DONE
module auto_player #(
  parameter int SONG_BITS   = 3,
  parameter int NUM_SONGS   = 8,
  parameter int CNT_BITS    = 8,
  parameter int OCTAVE_BITS = 2,
  parameter int NOTE_BITS   = 3,
  parameter int LENGTH_BITS = 3,
  parameter int TICK_DIV    = 100000,
  parameter int BASE_TICKS  = 125,
  parameter int GAP_TICKS   = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [SONG_BITS-1:0]   song_sel,
  input  logic                   pause_tgl,
  input  logic                   next_p,
  input  logic                   prev_p,
  input  logic [1:0]             repeat_mode,
  input  logic [1:0]             tempo,
  output logic [SONG_BITS-1:0]   rom_song,
  output logic [CNT_BITS-1:0]    rom_idx,
  input  logic [CNT_BITS-1:0]    rom_track,
  input  logic [OCTAVE_BITS-1:0] rom_octave,
  input  logic [NOTE_BITS-1:0]   rom_note,
  input  logic [LENGTH_BITS-1:0] rom_length,
  output logic [OCTAVE_BITS-1:0] octave,
  output logic [NOTE_BITS-1:0]   note,
  output logic                   gate,
  output logic [6:0]             led,
  output logic                   playing,
  output logic                   done
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  // Wide enough for (2^LENGTH_BITS)*BASE_TICKS so nothing is lost before the shift.
  localparam int DUR_W = LENGTH_BITS + $clog2(BASE_TICKS) + 1;
  localparam int GAP_W = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, PLAY, GAP, PAUSE, DONE} state_t;

  state_t             state;
  state_t             ret_state;
  state_t             step_state;
  logic [PRE_W-1:0]   pre;
  logic [DUR_W-1:0]   dur;
  logic [GAP_W-1:0]   gcnt;

  logic               tick;
  logic               phase_end;
  logic               to_gap;
  logic               at_last;
  logic               do_step;
  logic [DUR_W-1:0]   len_plus;
  logic [DUR_W-1:0]   dur_prod;
  logic [DUR_W-1:0]   dur_shift;
  logic [DUR_W-1:0]   dur_load;
  logic [SONG_BITS-1:0] song_inc;
  logic [SONG_BITS-1:0] song_dec;
  logic [6:0]         cur_led;
  logic [6:0]         new_led;

  function automatic logic [6:0] led_for(input logic [NOTE_BITS-1:0] n);
    led_for = 7'd0;
    if (n != '0) led_for = 7'd1 << (n - NOTE_BITS'(1));
  endfunction

  // Note duration in ticks for the note being loaded; a zero result after the
  // tempo shift is promoted to one tick so every note is audible.
  assign len_plus  = DUR_W'(rom_length) + DUR_W'(1);
  assign dur_prod  = len_plus * DUR_W'(BASE_TICKS);
  assign dur_shift = dur_prod >> tempo;
  assign dur_load  = (dur_shift == '0) ? DUR_W'(1) : dur_shift;

  assign song_inc = (rom_song == SONG_BITS'(NUM_SONGS - 1)) ? '0 : rom_song + SONG_BITS'(1);
  assign song_dec = (rom_song == '0) ? SONG_BITS'(NUM_SONGS - 1) : rom_song - SONG_BITS'(1);

  assign cur_led = led_for(note);
  assign new_led = led_for(rom_note);

  // The resume edge out of PAUSE counts as a normal step of the saved phase,
  // so the edge that enters PAUSE does not count; total note length is kept.
  assign step_state = (state == PAUSE) ? ret_state : state;
  assign do_step    = ((state == PLAY || state == GAP) && !pause_tgl) ||
                      (state == PAUSE && pause_tgl);
  assign tick       = (pre == PRE_W'(TICK_DIV - 1));
  assign phase_end  = tick && ((step_state == PLAY) ? (dur == DUR_W'(1))
                                                    : (gcnt == GAP_W'(1)));
  assign to_gap     = (step_state == PLAY) && (GAP_TICKS != 0);
  assign at_last    = !(rom_idx < rom_track);

  // Single FSM register block. Outputs are assigned from the state being
  // entered so they line up with the registered state; later assignments in
  // the step section override the hold-in-phase defaults on transitions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ret_state <= PLAY;
      pre       <= '0;
      dur       <= '0;
      gcnt      <= '0;
      rom_song  <= '0;
      rom_idx   <= '0;
      octave    <= '0;
      note      <= '0;
      gate      <= 1'b0;
      led       <= 7'd0;
      playing   <= 1'b0;
      done      <= 1'b0;
    end else if (state == IDLE) begin
      rom_song <= song_sel;
      rom_idx  <= '0;
      octave   <= '0;
      note     <= '0;
      gate     <= 1'b0;
      led      <= 7'd0;
      done     <= 1'b0;
      playing  <= en;
      state    <= en ? LOAD : IDLE;
    end else if (!en) begin
      state   <= IDLE;
      octave  <= '0;
      note    <= '0;
      gate    <= 1'b0;
      led     <= 7'd0;
      playing <= 1'b0;
      done    <= 1'b0;
    end else if (next_p || prev_p) begin
      rom_song <= next_p ? song_inc : song_dec;
      rom_idx  <= '0;
      state    <= LOAD;
      gate     <= 1'b0;
      led      <= 7'd0;
      playing  <= 1'b1;
      done     <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          octave  <= rom_octave;
          note    <= rom_note;
          dur     <= dur_load;
          pre     <= '0;
          state   <= PLAY;
          gate    <= (rom_note != '0);
          led     <= new_led;
          playing <= 1'b1;
        end
        PLAY, GAP: begin
          if (pause_tgl) begin
            ret_state <= state;
            state     <= PAUSE;
            gate      <= 1'b0;
            led       <= 7'd0;
            playing   <= 1'b0;
          end
        end
        default: ;
      endcase

      if (do_step) begin
        pre     <= tick ? '0 : pre + PRE_W'(1);
        state   <= step_state;
        gate    <= (step_state == PLAY) && (note != '0);
        led     <= (step_state == PLAY) ? cur_led : 7'd0;
        playing <= 1'b1;
        if (tick && !phase_end) begin
          if (step_state == PLAY) dur <= dur - DUR_W'(1);
          else gcnt <= gcnt - GAP_W'(1);
        end
        if (phase_end) begin
          gate <= 1'b0;
          led  <= 7'd0;
          if (to_gap) begin
            state <= GAP;
            gcnt  <= GAP_W'(GAP_TICKS);
          end else if (!at_last) begin
            rom_idx <= rom_idx + CNT_BITS'(1);
            state   <= LOAD;
          end else begin
            case (repeat_mode)
              2'b01: begin
                rom_idx <= '0;
                state   <= LOAD;
              end
              2'b10: begin
                state   <= DONE;
                playing <= 1'b0;
                done    <= 1'b1;
              end
              default: begin
                rom_song <= song_inc;
                rom_idx  <= '0;
                state    <= LOAD;
              end
            endcase
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_auto_player.sv
// tb_auto_player
// Self-checking bench for auto_player with TICK_DIV=4, BASE_TICKS=2,
// GAP_TICKS=1. Directed scenarios use hand-derived cycle counts; the random
// scenario compares every cycle against a note-list timeline model.
module tb_auto_player;

  localparam int TICK = 4;
  localparam int BASE = 2;
  localparam int GAPT = 1;

  logic       clk;
  logic       rst;
  logic       en;
  logic [2:0] song_sel;
  logic       pause_tgl;
  logic       next_p;
  logic       prev_p;
  logic [1:0] repeat_mode;
  logic [1:0] tempo;
  logic [2:0] rom_song;
  logic [7:0] rom_idx;
  logic [7:0] rom_track;
  logic [1:0] rom_octave;
  logic [2:0] rom_note;
  logic [2:0] rom_length;
  logic [1:0] octave;
  logic [2:0] note;
  logic       gate;
  logic [6:0] led;
  logic       playing;
  logic       done;

  logic [1:0] mem_oct   [8][256];
  logic [2:0] mem_note  [8][256];
  logic [2:0] mem_len   [8][256];
  logic [7:0] mem_track [8];

  int checks;
  int passed;

  typedef struct packed {
    logic       gate;
    logic [6:0] led;
    logic       playing;
    logic       done;
    logic [1:0] octave;
    logic [2:0] note;
    logic [2:0] song;
    logic [7:0] idx;
  } row_t;

  row_t exp_q[$];

  assign rom_octave = mem_oct[rom_song][rom_idx];
  assign rom_note   = mem_note[rom_song][rom_idx];
  assign rom_length = mem_len[rom_song][rom_idx];
  assign rom_track  = mem_track[rom_song];

  auto_player #(
    .SONG_BITS(3), .NUM_SONGS(8), .CNT_BITS(8),
    .OCTAVE_BITS(2), .NOTE_BITS(3), .LENGTH_BITS(3),
    .TICK_DIV(TICK), .BASE_TICKS(BASE), .GAP_TICKS(GAPT)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .song_sel(song_sel),
    .pause_tgl(pause_tgl), .next_p(next_p), .prev_p(prev_p),
    .repeat_mode(repeat_mode), .tempo(tempo),
    .rom_song(rom_song), .rom_idx(rom_idx), .rom_track(rom_track),
    .rom_octave(rom_octave), .rom_note(rom_note), .rom_length(rom_length),
    .octave(octave), .note(note), .gate(gate), .led(led),
    .playing(playing), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] time limit");
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic clear_rom();
    for (int s = 0; s < 8; s++) begin
      mem_track[s] = 8'd0;
      for (int i = 0; i < 256; i++) begin
        mem_oct[s][i]  = 2'd0;
        mem_note[s][i] = 3'd0;
        mem_len[s][i]  = 3'd0;
      end
    end
  endtask

  task automatic set_note(input int s, input int i, input int oc, input int n, input int l);
    mem_oct[s][i]  = 2'(oc);
    mem_note[s][i] = 3'(n);
    mem_len[s][i]  = 3'(l);
  endtask

  task automatic go_idle();
    en = 1'b0; pause_tgl = 1'b0; next_p = 1'b0; prev_p = 1'b0;
    cyc();
    cyc();
  endtask

  // Raise en; returns at the sample of the LOAD cycle.
  task automatic start(input int s);
    song_sel = 3'(s);
    en = 1'b1;
    cyc();
  endtask

  // Counts consecutive samples (starting with the current one) where gate
  // equals val, bounded by budget.
  task automatic run_len(input logic val, input int budget, output int len);
    len = 0;
    while (gate === val && len < budget) begin
      len++;
      cyc();
    end
  endtask

  function automatic row_t mk_row(input bit g, input int oc, input int nt, input bit pl,
                                  input bit dn, input int sg, input int ix);
    row_t r;
    r.gate    = g;
    r.led     = (g && nt != 0) ? 7'(1 << (nt - 1)) : 7'd0;
    r.playing = pl;
    r.done    = dn;
    r.octave  = 2'(oc);
    r.note    = 3'(nt);
    r.song    = 3'(sg);
    r.idx     = 8'(ix);
    return r;
  endfunction

  // Timeline model: each note is one LOAD cycle, then its gate time, then the
  // gap, followed by the repeat-mode decision at the end of a song.
  task automatic build_model(input int s, input int t, input int m, input int nrows);
    int song, idx, d, oc, nt;
    exp_q.delete();
    song = s; idx = 0; oc = 0; nt = 0;
    while (exp_q.size() < nrows) begin
      exp_q.push_back(mk_row(1'b0, oc, nt, 1'b1, 1'b0, song, idx));
      oc = int'(mem_oct[song][idx]);
      nt = int'(mem_note[song][idx]);
      d = ((int'(mem_len[song][idx]) + 1) * BASE) >> t;
      if (d == 0) d = 1;
      for (int k = 0; k < d * TICK; k++)
        exp_q.push_back(mk_row(nt != 0, oc, nt, 1'b1, 1'b0, song, idx));
      for (int k = 0; k < GAPT * TICK; k++)
        exp_q.push_back(mk_row(1'b0, oc, nt, 1'b1, 1'b0, song, idx));
      if (idx < int'(mem_track[song])) idx++;
      else if (m == 1) idx = 0;
      else if (m == 2) begin
        while (exp_q.size() < nrows)
          exp_q.push_back(mk_row(1'b0, oc, nt, 1'b0, 1'b1, song, idx));
      end else begin
        song = (song + 1) % 8;
        idx = 0;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc();
    cyc();
    checks++;
    if ({gate, led, playing, done, octave, note} !== 15'd0)
      $display("[TB] FAIL reset_outputs: got %h expected 0", {gate, led, playing, done, octave, note});
    else passed++;
    checks++;
    if ({rom_song, rom_idx} !== 11'd0)
      $display("[TB] FAIL reset_rom_addr: got song %0d idx %0d expected 0 0", rom_song, rom_idx);
    else passed++;
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_basic();
    int n;
    clear_rom();
    set_note(0, 0, 1, 1, 1);
    set_note(0, 1, 2, 3, 0);
    mem_track[0] = 8'd1;
    set_note(1, 0, 0, 5, 0);
    repeat_mode = 2'b00; tempo = 2'd0;
    go_idle();
    start(0);
    checks++;
    if ({playing, gate} !== 2'b10)
      $display("[TB] FAIL basic_load: got playing %b gate %b expected 1 0", playing, gate);
    else passed++;
    cyc();
    checks++;
    if ({led, octave, note} !== {7'b0000001, 2'd1, 3'd1})
      $display("[TB] FAIL basic_led1: got led %b oct %0d note %0d expected 0000001 1 1", led, octave, note);
    else passed++;
    run_len(1'b1, 40, n);
    checks++;
    if (n !== 16) $display("[TB] FAIL basic_gate1: got %0d cycles expected 16", n);
    else passed++;
    run_len(1'b0, 40, n);
    checks++;
    if (n !== 5) $display("[TB] FAIL basic_gap1: got %0d low cycles expected 5", n);
    else passed++;
    checks++;
    if (led !== 7'b0000100) $display("[TB] FAIL basic_led3: got %b expected 0000100", led);
    else passed++;
    run_len(1'b1, 40, n);
    checks++;
    if (n !== 8) $display("[TB] FAIL basic_gate2: got %0d cycles expected 8", n);
    else passed++;
    run_len(1'b0, 40, n);
    checks++;
    if (n !== 5) $display("[TB] FAIL basic_gap2: got %0d low cycles expected 5", n);
    else passed++;
    checks++;
    if ({rom_song, rom_idx, note} !== {3'd1, 8'd0, 3'd5})
      $display("[TB] FAIL basic_advance: got song %0d idx %0d note %0d expected 1 0 5", rom_song, rom_idx, note);
    else passed++;
  endtask

  task automatic test_tempo();
    int n;
    clear_rom();
    set_note(2, 0, 3, 2, 0);
    repeat_mode = 2'b01; tempo = 2'd2;
    go_idle();
    start(2);
    cyc();
    checks++;
    if (led !== 7'b0000010) $display("[TB] FAIL tempo_led: got %b expected 0000010", led);
    else passed++;
    tempo = 2'd0;
    run_len(1'b1, 20, n);
    checks++;
    if (n !== 4) $display("[TB] FAIL tempo_shift: got %0d cycles expected 4", n);
    else passed++;
    run_len(1'b0, 20, n);
    checks++;
    if (n !== 5) $display("[TB] FAIL tempo_gap: got %0d low cycles expected 5", n);
    else passed++;
    run_len(1'b1, 20, n);
    checks++;
    if (n !== 8) $display("[TB] FAIL tempo_reload: got %0d cycles expected 8", n);
    else passed++;
  endtask

  task automatic test_pause();
    int n, high, lows;
    clear_rom();
    set_note(3, 0, 0, 4, 1);
    repeat_mode = 2'b01; tempo = 2'd0;
    go_idle();
    start(3);
    high = 0;
    for (int k = 0; k < 6; k++) begin
      cyc();
      if (gate === 1'b1) high++;
    end
    checks++;
    if (high !== 6) $display("[TB] FAIL pause_pre: got %0d high cycles expected 6", high);
    else passed++;
    pause_tgl = 1'b1;
    cyc();
    pause_tgl = 1'b0;
    lows = 0;
    for (int i = 0; i < 20; i++) begin
      if (gate === 1'b0 && led === 7'd0) lows++;
      if (i < 19) cyc();
    end
    checks++;
    if (lows !== 20) $display("[TB] FAIL pause_low: got %0d silent cycles expected 20", lows);
    else passed++;
    checks++;
    if ({note, playing} !== {3'd4, 1'b0})
      $display("[TB] FAIL pause_hold: got note %0d playing %b expected 4 0", note, playing);
    else passed++;
    pause_tgl = 1'b1;
    cyc();
    pause_tgl = 1'b0;
    run_len(1'b1, 40, n);
    checks++;
    if (n !== 10) $display("[TB] FAIL pause_resume: got %0d cycles expected 10", n);
    else passed++;
  endtask

  task automatic test_song_wrap();
    clear_rom();
    set_note(7, 0, 1, 2, 3);
    set_note(0, 0, 0, 1, 1);
    repeat_mode = 2'b00; tempo = 2'd0;
    go_idle();
    start(7);
    cyc();
    next_p = 1'b1;
    cyc();
    next_p = 1'b0;
    checks++;
    if ({rom_song, rom_idx, playing, gate} !== {3'd0, 8'd0, 1'b1, 1'b0})
      $display("[TB] FAIL next_wrap: got song %0d idx %0d playing %b gate %b expected 0 0 1 0",
               rom_song, rom_idx, playing, gate);
    else passed++;
    cyc();
    checks++;
    if ({gate, note} !== {1'b1, 3'd1})
      $display("[TB] FAIL next_plays: got gate %b note %0d expected 1 1", gate, note);
    else passed++;
    prev_p = 1'b1;
    cyc();
    prev_p = 1'b0;
    checks++;
    if ({rom_song, rom_idx} !== {3'd7, 8'd0})
      $display("[TB] FAIL prev_wrap: got song %0d idx %0d expected 7 0", rom_song, rom_idx);
    else passed++;
    cyc();
    next_p = 1'b1; prev_p = 1'b1;
    cyc();
    next_p = 1'b0; prev_p = 1'b0;
    checks++;
    if (rom_song !== 3'd0) $display("[TB] FAIL next_over_prev: got song %0d expected 0", rom_song);
    else passed++;
  endtask

  task automatic test_stop();
    int n, w, bad;
    clear_rom();
    set_note(4, 0, 1, 6, 0);
    set_note(5, 0, 2, 7, 0);
    repeat_mode = 2'b10; tempo = 2'd0;
    go_idle();
    start(4);
    cyc();
    checks++;
    if (led !== 7'b0100000) $display("[TB] FAIL stop_led: got %b expected 0100000", led);
    else passed++;
    run_len(1'b1, 40, n);
    checks++;
    if (n !== 8) $display("[TB] FAIL stop_gate: got %0d cycles expected 8", n);
    else passed++;
    w = 0;
    while (done !== 1'b1 && w < 20) begin
      w++;
      cyc();
    end
    checks++;
    if (w !== 4) $display("[TB] FAIL stop_gap: got %0d cycles before done expected 4", w);
    else passed++;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      if (done !== 1'b1 || gate !== 1'b0 || playing !== 1'b0) bad++;
      cyc();
    end
    checks++;
    if (bad !== 0) $display("[TB] FAIL stop_hold: got %0d bad cycles expected 0", bad);
    else passed++;
    next_p = 1'b1;
    cyc();
    next_p = 1'b0;
    checks++;
    if ({done, playing, rom_song, rom_idx} !== {1'b0, 1'b1, 3'd5, 8'd0})
      $display("[TB] FAIL stop_next: got done %b playing %b song %0d idx %0d expected 0 1 5 0",
               done, playing, rom_song, rom_idx);
    else passed++;
  endtask

  task automatic test_en_reset();
    clear_rom();
    set_note(0, 0, 1, 1, 7);
    set_note(5, 0, 2, 3, 7);
    repeat_mode = 2'b00; tempo = 2'd0;
    go_idle();
    start(0);
    cyc();
    cyc();
    cyc();
    en = 1'b0;
    cyc();
    checks++;
    if ({playing, gate, led} !== 9'd0)
      $display("[TB] FAIL en_low_idle: got playing %b gate %b led %b expected 0 0 0", playing, gate, led);
    else passed++;
    song_sel = 3'd5;
    cyc();
    en = 1'b1;
    cyc();
    checks++;
    if ({rom_song, rom_idx, playing} !== {3'd5, 8'd0, 1'b1})
      $display("[TB] FAIL en_restart: got song %0d idx %0d playing %b expected 5 0 1", rom_song, rom_idx, playing);
    else passed++;
    cyc();
    checks++;
    if ({gate, note} !== {1'b1, 3'd3})
      $display("[TB] FAIL pre_reset_play: got gate %b note %0d expected 1 3", gate, note);
    else passed++;
    rst = 1'b1;
    #1;
    checks++;
    if ({gate, led, playing, done, octave, note, rom_song, rom_idx} !== 26'd0)
      $display("[TB] FAIL async_reset: got %h expected 0",
               {gate, led, playing, done, octave, note, rom_song, rom_idx});
    else passed++;
    cyc();
    rst = 1'b0;
    song_sel = 3'd0;
    cyc();
  endtask

  task automatic test_random();
    int s, t, m;
    row_t act;
    for (int r = 0; r < 4; r++) begin
      go_idle();
      for (int sg = 0; sg < 8; sg++) begin
        mem_track[sg] = 8'($urandom_range(0, 3));
        for (int i = 0; i < 4; i++)
          set_note(sg, i, int'($urandom_range(0, 3)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
      end
      s = int'($urandom_range(0, 7));
      t = int'($urandom_range(0, 3));
      m = int'($urandom_range(0, 3));
      build_model(s, t, m, 200);
      song_sel = 3'(s); tempo = 2'(t); repeat_mode = 2'(m);
      en = 1'b1;
      for (int i = 0; i < 200; i++) begin
        cyc();
        act = {gate, led, playing, done, octave, note, rom_song, rom_idx};
        checks++;
        if (act !== exp_q[i])
          $display("[TB] FAIL random_run%0d_cycle%0d: got %h expected %h (song %0d tempo %0d mode %0d)",
                   r, i, act, exp_q[i], s, t, m);
        else passed++;
      end
    end
  endtask

  initial begin
    checks = 0; passed = 0;
    rst = 1'b1; en = 1'b0; song_sel = 3'd0;
    pause_tgl = 1'b0; next_p = 1'b0; prev_p = 1'b0;
    repeat_mode = 2'b00; tempo = 2'd0;
    clear_rom();
    test_reset();
    test_basic();
    test_tempo();
    test_pause();
    test_song_wrap();
    test_stop();
    test_en_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
